// File: rtl/rx_fsm.sv
// rx_fsm: receive-side packet engine. Takes flits one at a time from the
// network port, writes each one (header included) into a free slot of the RX
// message buffer over the bus master port, returns one credit per flit, and
// publishes the slot as valid with its length and source once the packet is
// stored.
module rx_fsm #(
  parameter int          NUM_MSGS     = 4,
  parameter int          SLOT_WORDS   = 16,
  parameter logic [31:0] RX_BASE_ADDR = 32'h2000,
  parameter int          LEN_W        = 8,
  parameter int          ID_W         = 2,
  parameter int          NODE_W       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flit_valid,
  input  logic [31:0]                flit_payload,
  input  logic [ID_W-1:0]            flit_id,
  input  logic [NODE_W-1:0]          flit_req,
  output logic                       flit_ready,
  output logic                       credit_return,
  output logic [31:0]                bus_addr,
  output logic                       bus_wen,
  output logic [31:0]                bus_wdata,
  output logic [3:0]                 bus_strobe,
  input  logic                       bus_request_stall,
  input  logic [NUM_MSGS-1:0]        rx_clear,
  output logic [NUM_MSGS-1:0]        rx_valid,
  output logic [NUM_MSGS*LEN_W-1:0]  rx_len,
  output logic [NUM_MSGS*NODE_W-1:0] rx_src,
  output logic                       rx_done,
  output logic                       rx_err
);

  localparam int SLOT_W = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;
  localparam int K_W    = $clog2(SLOT_WORDS + 1);
  localparam logic [K_W-1:0] K_MAX   = K_W'(SLOT_WORDS);
  localparam logic [K_W:0]   LEN_MAX = (K_W + 1)'(SLOT_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    RECV,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slotIdx_q, slotIdx_d;
  logic [31:0]         holdData_q, holdData_d;
  logic [ID_W-1:0]     hdrId_q, hdrId_d;
  logic [NODE_W-1:0]   srcNode_q, srcNode_d;
  logic [LEN_W-1:0]    remaining_q, remaining_d;
  logic [K_W-1:0]      wordIdx_q, wordIdx_d;
  logic                ovfSeen_q, ovfSeen_d;
  logic                credit_q, credit_d;
  logic                err_q, err_d;
  logic [NUM_MSGS-1:0] rxValid_q, rxValid_d;
  logic [LEN_W-1:0]    rxLen_q [NUM_MSGS];
  logic [LEN_W-1:0]    rxLen_d [NUM_MSGS];
  logic [NODE_W-1:0]   rxSrc_q [NUM_MSGS];
  logic [NODE_W-1:0]   rxSrc_d [NUM_MSGS];

  logic                anyFree;
  logic [SLOT_W-1:0]   freeSlot;
  logic [NUM_MSGS-1:0] reservedMask;
  logic                skipWrite;
  logic [K_W-1:0]      wordIdxInc;
  logic [K_W:0]        kPlusOne;
  logic [LEN_W-1:0]    lenSat;
  logic [31:0]         wordOffset;
  logic [31:0]         writeAddr;

  // Slot bookkeeping: lowest free slot, the slot held by the packet in
  // flight, and the word index / length arithmetic for the current write.
  always_comb begin
    anyFree      = |(~rxValid_q);
    freeSlot     = '0;
    reservedMask = '0;
    for (int i = NUM_MSGS - 1; i >= 0; i--) begin
      if (!rxValid_q[i]) begin
        freeSlot = SLOT_W'(i);
      end
    end
    if (state_q != IDLE) begin
      reservedMask[slotIdx_q] = 1'b1;
    end
    skipWrite  = (wordIdx_q >= K_MAX);
    wordIdxInc = skipWrite ? wordIdx_q : wordIdx_q + 1'b1;
    kPlusOne   = {1'b0, wordIdx_q} + 1'b1;
    lenSat     = (kPlusOne > LEN_MAX) ? LEN_W'(LEN_MAX) : LEN_W'(kPlusOne);
    wordOffset = 32'(slotIdx_q) * 32'(SLOT_WORDS) + 32'(wordIdx_q);
    writeAddr  = RX_BASE_ADDR + (wordOffset << 2);
  end

  // Next-state and output decode; flit_ready depends only on state and slot
  // occupancy, and is held low while reset is asserted.
  always_comb begin
    state_d     = state_q;
    slotIdx_d   = slotIdx_q;
    holdData_d  = holdData_q;
    hdrId_d     = hdrId_q;
    srcNode_d   = srcNode_q;
    remaining_d = remaining_q;
    wordIdx_d   = wordIdx_q;
    ovfSeen_d   = ovfSeen_q;
    credit_d    = 1'b0;
    err_d       = 1'b0;
    rxValid_d   = rxValid_q & ~(rx_clear & ~reservedMask);
    rxLen_d     = rxLen_q;
    rxSrc_d     = rxSrc_q;
    flit_ready  = 1'b0;
    bus_wen     = 1'b0;
    bus_addr    = '0;
    bus_wdata   = '0;
    rx_done     = 1'b0;

    case (state_q)
      IDLE: begin
        flit_ready = anyFree && !rst;
        if (flit_valid && anyFree) begin
          slotIdx_d   = freeSlot;
          holdData_d  = flit_payload;
          hdrId_d     = flit_id;
          srcNode_d   = flit_req;
          remaining_d = flit_payload[LEN_W-1:0];
          wordIdx_d   = '0;
          ovfSeen_d   = 1'b0;
          credit_d    = 1'b1;
          state_d     = WRITE;
        end
      end

      WRITE: begin
        if (!skipWrite) begin
          bus_wen   = 1'b1;
          bus_addr  = writeAddr;
          bus_wdata = holdData_q;
        end else if (!ovfSeen_q) begin
          err_d     = 1'b1;
          ovfSeen_d = 1'b1;
        end
        if (skipWrite || !bus_request_stall) begin
          if (remaining_q == '0) begin
            state_d = DONE;
          end else begin
            state_d   = RECV;
            wordIdx_d = wordIdxInc;
          end
        end
      end

      RECV: begin
        flit_ready = 1'b1;
        if (flit_valid) begin
          holdData_d  = flit_payload;
          remaining_d = remaining_q - 1'b1;
          credit_d    = 1'b1;
          if (flit_id != hdrId_q) begin
            err_d = 1'b1;
          end
          state_d = WRITE;
        end
      end

      DONE: begin
        rx_done              = 1'b1;
        rxValid_d[slotIdx_q] = 1'b1;
        rxLen_d[slotIdx_q]   = lenSat;
        rxSrc_d[slotIdx_q]   = srcNode_q;
        state_d              = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and holding registers; reset aborts any packet in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      slotIdx_q   <= '0;
      holdData_q  <= '0;
      hdrId_q     <= '0;
      srcNode_q   <= '0;
      remaining_q <= '0;
      wordIdx_q   <= '0;
      ovfSeen_q   <= 1'b0;
      credit_q    <= 1'b0;
      err_q       <= 1'b0;
      rxValid_q   <= '0;
      for (int i = 0; i < NUM_MSGS; i++) begin
        rxLen_q[i] <= '0;
        rxSrc_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      slotIdx_q   <= slotIdx_d;
      holdData_q  <= holdData_d;
      hdrId_q     <= hdrId_d;
      srcNode_q   <= srcNode_d;
      remaining_q <= remaining_d;
      wordIdx_q   <= wordIdx_d;
      ovfSeen_q   <= ovfSeen_d;
      credit_q    <= credit_d;
      err_q       <= err_d;
      rxValid_q   <= rxValid_d;
      rxLen_q     <= rxLen_d;
      rxSrc_q     <= rxSrc_d;
    end
  end

  // Flatten the per-slot status registers onto the output buses.
  always_comb begin
    rx_len = '0;
    rx_src = '0;
    for (int i = 0; i < NUM_MSGS; i++) begin
      rx_len[i*LEN_W +: LEN_W]   = rxLen_q[i];
      rx_src[i*NODE_W +: NODE_W] = rxSrc_q[i];
    end
  end

  assign rx_valid      = rxValid_q;
  assign credit_return = credit_q;
  assign rx_err        = err_q;
  assign bus_strobe    = bus_wen ? 4'hF : 4'h0;

endmodule

// File: tb/tb_rx_fsm.sv
// tb_rx_fsm: directed bench for rx_fsm. A table of packets is pushed through
// slot 0 one after another, followed by hand-written sequences for slot
// exhaustion with rx_clear and for a reset in the middle of a packet.
module tb_rx_fsm;

  localparam int NUM_MSGS = 4;
  localparam int LEN_W    = 8;
  localparam int NODE_W   = 4;

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       flit_valid = 1'b0;
  logic [31:0]                flit_payload = '0;
  logic [1:0]                 flit_id = '0;
  logic [3:0]                 flit_req = '0;
  logic                       flit_ready;
  logic                       credit_return;
  logic [31:0]                bus_addr;
  logic                       bus_wen;
  logic [31:0]                bus_wdata;
  logic [3:0]                 bus_strobe;
  logic                       bus_request_stall = 1'b0;
  logic [NUM_MSGS-1:0]        rx_clear = '0;
  logic [NUM_MSGS-1:0]        rx_valid;
  logic [NUM_MSGS*LEN_W-1:0]  rx_len;
  logic [NUM_MSGS*NODE_W-1:0] rx_src;
  logic                       rx_done;
  logic                       rx_err;

  rx_fsm dut (
    .clk              (clk),
    .rst              (rst),
    .flit_valid       (flit_valid),
    .flit_payload     (flit_payload),
    .flit_id          (flit_id),
    .flit_req         (flit_req),
    .flit_ready       (flit_ready),
    .credit_return    (credit_return),
    .bus_addr         (bus_addr),
    .bus_wen          (bus_wen),
    .bus_wdata        (bus_wdata),
    .bus_strobe       (bus_strobe),
    .bus_request_stall(bus_request_stall),
    .rx_clear         (rx_clear),
    .rx_valid         (rx_valid),
    .rx_len           (rx_len),
    .rx_src           (rx_src),
    .rx_done          (rx_done),
    .rx_err           (rx_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         n;
    int         stallLen;
    logic [1:0] bodyId;
    logic [3:0] req;
    int         expWrites;
    int         expCredits;
    int         expErrs;
    int         expLen;
  } vec_t;

  int          checks = 0;
  int          passes = 0;
  int          stallLen = 0;
  int          stallCnt = 0;
  bit          stalledPrev = 1'b0;
  logic [31:0] heldAddr = '0;
  logic [31:0] heldData = '0;
  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];
  int          creditCnt = 0;
  int          errCnt = 0;
  int          doneCnt = 0;
  int          negCnt = 0;
  int          consumeNeg = 0;
  int          doneNeg = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bodyWord(input int v, input int j);
    return 32'hB000_0000 | (32'(v) << 16) | 32'(j);
  endfunction

  task automatic clearMonitor();
    wrAddr.delete();
    wrData.delete();
    creditCnt = 0;
    errCnt    = 0;
    doneCnt   = 0;
  endtask

  // Presents one flit and holds it until the DUT consumes it.
  task automatic applyStimulus(input logic [31:0] payload, input logic [1:0] id, input logic [3:0] req);
    int waitCnt = 0;
    flit_valid   = 1'b1;
    flit_payload = payload;
    flit_id      = id;
    flit_req     = req;
    @(negedge clk);
    while (!flit_ready && waitCnt < 200) begin
      @(negedge clk);
      waitCnt++;
    end
    if (!flit_ready) checkOutput("flit_ready_timeout", 32'(flit_ready), 32'd1);
    @(posedge clk);
    #1;
    flit_valid = 1'b0;
  endtask

  task automatic waitDone(input int target);
    int waitCnt = 0;
    while (doneCnt < target && waitCnt < 400) begin
      @(negedge clk);
      waitCnt++;
    end
    if (doneCnt < target) checkOutput("rx_done_timeout", 32'(doneCnt), 32'(target));
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  // Bus slave model and event counters, sampled mid-cycle. The stall decision
  // made here is what the DUT sees at the following rising edge.
  always @(negedge clk) begin
    negCnt++;
    if (flit_valid && flit_ready) consumeNeg = negCnt;
    if (credit_return) creditCnt++;
    if (rx_err) errCnt++;
    if (rx_done) begin
      doneCnt++;
      doneNeg = negCnt;
    end
    if (bus_wen) begin
      if (stalledPrev) begin
        checkOutput("stall_hold_addr", bus_addr, heldAddr);
        checkOutput("stall_hold_data", bus_wdata, heldData);
      end
      if (stallCnt < stallLen) begin
        bus_request_stall = 1'b1;
        stallCnt++;
        stalledPrev = 1'b1;
        heldAddr = bus_addr;
        heldData = bus_wdata;
      end else begin
        bus_request_stall = 1'b0;
        stallCnt = 0;
        stalledPrev = 1'b0;
        checkOutput("bus_strobe", 32'(bus_strobe), 32'hF);
        wrAddr.push_back(bus_addr);
        wrData.push_back(bus_wdata);
      end
    end else begin
      if (stalledPrev) checkOutput("stall_hold_wen", 32'(bus_wen), 32'd1);
      bus_request_stall = 1'b0;
      stallCnt = 0;
      stalledPrev = 1'b0;
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vec_t        vecs[5];
    logic [31:0] hdr;
    logic [31:0] expData;
    int          readyHigh;
    int          waitCnt;

    vecs[0] = '{n:0,  stallLen:0, bodyId:2'd0, req:4'd3,  expWrites:1,  expCredits:1,  expErrs:0, expLen:1};
    vecs[1] = '{n:3,  stallLen:2, bodyId:2'd0, req:4'd5,  expWrites:4,  expCredits:4,  expErrs:0, expLen:4};
    vecs[2] = '{n:2,  stallLen:0, bodyId:2'd1, req:4'd9,  expWrites:3,  expCredits:3,  expErrs:2, expLen:3};
    vecs[3] = '{n:20, stallLen:0, bodyId:2'd0, req:4'd12, expWrites:16, expCredits:21, expErrs:1, expLen:16};
    vecs[4] = '{n:1,  stallLen:1, bodyId:2'd0, req:4'd1,  expWrites:2,  expCredits:2,  expErrs:0, expLen:2};

    // Reset state while rst is still asserted.
    @(negedge clk);
    checkOutput("reset_ctrl", 32'({flit_ready, credit_return, bus_wen, rx_done, rx_err, bus_strobe}), 32'd0);
    checkOutput("reset_bus_addr", bus_addr, 32'd0);
    checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_rx_len", rx_len, 32'd0);
    checkOutput("reset_rx_src", 32'(rx_src), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("idle_ready", 32'(flit_ready), 32'd1);
    @(posedge clk);
    #1;

    // Table of packets, each landing in slot 0 and released afterwards.
    for (int i = 0; i < 5; i++) begin
      clearMonitor();
      stallLen = vecs[i].stallLen;
      hdr = (32'(i) << 24) | 32'(vecs[i].n);
      applyStimulus(hdr, 2'd0, vecs[i].req);
      for (int j = 1; j <= vecs[i].n; j++) begin
        applyStimulus(bodyWord(i, j), vecs[i].bodyId, ~vecs[i].req);
      end
      waitDone(1);
      if (vecs[i].n == 0) checkOutput($sformatf("v%0d_done_latency", i), 32'(doneNeg - consumeNeg), 32'd2);
      checkOutput($sformatf("v%0d_rx_valid", i), 32'(rx_valid), 32'd1);
      checkOutput($sformatf("v%0d_rx_len", i), 32'(rx_len[7:0]), 32'(vecs[i].expLen));
      checkOutput($sformatf("v%0d_rx_src", i), 32'(rx_src[3:0]), 32'(vecs[i].req));
      checkOutput($sformatf("v%0d_write_count", i), 32'(wrAddr.size()), 32'(vecs[i].expWrites));
      for (int w = 0; w < vecs[i].expWrites; w++) begin
        expData = (w == 0) ? hdr : bodyWord(i, w);
        if (w < wrAddr.size()) begin
          checkOutput($sformatf("v%0d_addr%0d", i, w), wrAddr[w], 32'h2000 + 32'(w) * 4);
          checkOutput($sformatf("v%0d_data%0d", i, w), wrData[w], expData);
        end
      end
      checkOutput($sformatf("v%0d_credits", i), 32'(creditCnt), 32'(vecs[i].expCredits));
      checkOutput($sformatf("v%0d_errs", i), 32'(errCnt), 32'(vecs[i].expErrs));
      checkOutput($sformatf("v%0d_dones", i), 32'(doneCnt), 32'd1);
      rx_clear = 4'b0001;
      @(posedge clk);
      #1;
      rx_clear = 4'b0000;
      @(negedge clk);
      checkOutput($sformatf("v%0d_cleared", i), 32'(rx_valid), 32'd0);
      @(posedge clk);
      #1;
    end
    stallLen = 0;

    // Fill every slot, then a fifth header must wait until slot 2 is freed.
    clearMonitor();
    for (int s = 0; s < 4; s++) begin
      applyStimulus(32'h0, 2'd0, 4'(s + 4));
      waitDone(s + 1);
    end
    checkOutput("fill_rx_valid", 32'(rx_valid), 32'hF);
    checkOutput("fill_rx_src", 32'(rx_src), 32'h7654);
    for (int s = 0; s < 4; s++) begin
      if (s < wrAddr.size()) checkOutput($sformatf("fill_addr%0d", s), wrAddr[s], 32'h2000 + 32'(s) * 64);
    end
    clearMonitor();
    flit_valid   = 1'b1;
    flit_payload = 32'h5500_0000;
    flit_id      = 2'd0;
    flit_req     = 4'hA;
    readyHigh    = 0;
    repeat (10) begin
      @(negedge clk);
      if (flit_ready) readyHigh++;
    end
    checkOutput("full_backpressure", 32'(readyHigh), 32'd0);
    @(posedge clk);
    #1;
    rx_clear = 4'b0100;
    @(posedge clk);
    #1;
    rx_clear = 4'b0000;
    applyStimulus(32'h5500_0000, 2'd0, 4'hA);
    waitDone(1);
    checkOutput("refill_write_count", 32'(wrAddr.size()), 32'd1);
    if (wrAddr.size() > 0) begin
      checkOutput("refill_addr", wrAddr[0], 32'h2080);
      checkOutput("refill_data", wrData[0], 32'h5500_0000);
    end
    checkOutput("refill_rx_valid", 32'(rx_valid), 32'hF);
    checkOutput("refill_rx_src", 32'(rx_src[11:8]), 32'hA);
    checkOutput("refill_rx_len", 32'(rx_len[23:16]), 32'd1);

    // Reset in the middle of a packet, then a fresh packet reuses slot 0.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clearMonitor();
    applyStimulus(32'h0000_0003, 2'd0, 4'h7);
    applyStimulus(32'hB100_0001, 2'd0, 4'h7);
    waitCnt = 0;
    @(negedge clk);
    while (!flit_ready && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    checkOutput("abort_reached_recv", 32'(flit_ready), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("abort_ctrl", 32'({flit_ready, credit_return, bus_wen, rx_done, rx_err, bus_strobe}), 32'd0);
    checkOutput("abort_rx_valid", 32'(rx_valid), 32'd0);
    checkOutput("abort_rx_len", rx_len, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 32'(doneCnt), 32'd0);
    clearMonitor();
    applyStimulus(32'h0, 2'd0, 4'h2);
    waitDone(1);
    checkOutput("after_abort_writes", 32'(wrAddr.size()), 32'd1);
    if (wrAddr.size() > 0) checkOutput("after_abort_addr", wrAddr[0], 32'h2000);
    checkOutput("after_abort_rx_valid", 32'(rx_valid), 32'd1);
    checkOutput("after_abort_rx_src", 32'(rx_src[3:0]), 32'h2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
